redun_sq_loop_ctrl: RTL and testbench
=====================================

// Module: redun_sq_loop_ctrl
// PURPOSE
// - Iteration controller directly upstream/downstream of the redundant Montgomery squaring wrapper.
// - Takes an initial redundant-form value and an iteration count T.
// - Issues one squaring to the wrapper, captures the returned value and feeds it back; repeats T times.
// - Presents the final redundant-form result to the host side. Runs entirely in the wrapper's i_clk domain.
// PARAMETERS
// - NUM_WRDS     65    number of redundant words per value
// - WRD_BITS     16    bits per redundant word (16 or 32)
// - ITER_BITS    40    width of the iteration counter
// - TIMEOUT_CYC  4096  max cycles from a squaring issue to its result before the abort
// - CHKPT_SHIFT  20    checkpoint every 2**CHKPT_SHIFT iterations (used only with the macro)
// PORTS
// - i_clk        in   1                  clock (single domain)
// - i_reset      in   1                  synchronous reset, active-high
// - i_start      in   1                  load request: valid for i_sq_init/i_iters
// - o_ready      out  1                  controller idle; load accepted when i_start&&o_ready
// - i_sq_init    in   NUM_WRDS*WRD_BITS  initial value (redundant form)
// - i_iters      in   ITER_BITS          number of squarings T
// - o_sq_start   out  1                  one-cycle issue pulse to the squaring wrapper
// - o_sq_data    out  NUM_WRDS*WRD_BITS  value to square; stable while not in ISSUE
// - i_sq_out     in   NUM_WRDS*WRD_BITS  squaring result from the wrapper
// - i_sq_valid   in   1                  result valid (single-cycle)
// - i_locked     in   1                  wrapper clock locked
// - o_result     out  NUM_WRDS*WRD_BITS  final value; held while o_val
// - o_val        out  1                  final result valid
// - i_rdy        in   1                  host accepts the result when o_val&&i_rdy
// - o_err        out  1                  one-cycle pulse on an abort (timeout or lock loss)
// - o_chkpt_val  out  1                  checkpoint pulse; o_result = intermediate value (macro only)
// BEHAVIOUR
// - Reset: state=IDLE; o_ready=1; o_sq_start=0; o_val=0; o_err=0; o_chkpt_val=0; o_sq_data=0; o_result=0; counters=0.
// - FSM states: IDLE, WAIT_LOCK, ISSUE, WAIT_RES, DONE.
// - IDLE, on i_start:
//   - capture i_sq_init into the working register and i_iters into cnt.
//   - i_iters==0: o_result=i_sq_init, next state DONE; nothing is issued.
//   - otherwise: next state WAIT_LOCK.
// - WAIT_LOCK: stay while !i_locked; go to ISSUE when i_locked=1. No timeout in this state.
// - ISSUE:
//   - o_sq_start=1 for exactly one cycle with o_sq_data=working register.
//   - clear the timeout counter; next state WAIT_RES.
// - WAIT_RES, on i_sq_valid:
//   - working register <= i_sq_out; cnt <= cnt-1.
//   - cnt==1 at capture: o_result <= i_sq_out, next state DONE.
//   - otherwise: next state ISSUE (back-to-back, 1 idle cycle).
// - Timeout: counter increments each cycle in WAIT_RES. At TIMEOUT_CYC-1 with no i_sq_valid:
//   o_err pulse, discard the work, go to IDLE.
// - Lock loss: i_locked=0 in ISSUE or WAIT_RES gives an o_err pulse and IDLE.
//   i_locked=0 in the same cycle as i_sq_valid is still an abort: lock loss wins.
// - DONE: o_val=1 and o_result held until i_rdy. Accept returns to IDLE next cycle; o_ready=1 that cycle.
// - o_ready=1 only in IDLE. i_start outside IDLE is ignored (no queueing).
// - i_sq_valid outside WAIT_RES is ignored: it does not change the working register or cnt.
// - Latency: T*(L+2)+2 cycles from load to o_val, where L = wrapper issue-to-valid latency (lock held).
// - cnt is unsigned ITER_BITS. T=2**ITER_BITS-1 must run to completion with no wrap.
// - i_reset mid-operation: immediate return to IDLE with reset output values. Late i_sq_valid is dropped.
// CONFIGURATION
// - Macro REDUN_LOOP_CHKPT_EN.
// - Defined:
//   - after each capture where the completed-iteration count mod 2**CHKPT_SHIFT == 0 and cnt!=0:
//     o_result <= captured value; o_chkpt_val pulses one cycle. Loop continues, no backpressure.
//   - DONE takes priority: no checkpoint pulse on the final iteration.
// - Undefined: o_chkpt_val tied 0; no checkpoint logic is built.
// TESTING
// - Load init=5 (word0=5, rest 0), T=3; wrapper model with L=10, returns x^2: exactly 3 o_sq_start pulses.
//   o_val with word0=390625; o_val first high at cycle 3*12+2=38 after the load.
// - T=0, init=0x1234: o_val 1 cycle after the load, o_result=0x1234, zero o_sq_start pulses.
// - i_locked=0 at the load, raised 50 cycles later: first o_sq_start 1 cycle after the rise.
//   Drop i_locked during WAIT_RES: o_err pulse, o_ready=1 next cycle.
// - Wrapper model never returns valid: o_err pulse TIMEOUT_CYC cycles after the issue, then IDLE.
//   A late i_sq_valid after that does not alter state.
// - Hold i_rdy=0 for 20 cycles in DONE: o_val and o_result stable; i_start pulses ignored.
//   Assert i_rdy, then reload: new run completes normally.
// - With REDUN_LOOP_CHKPT_EN, CHKPT_SHIFT=2, T=10: o_chkpt_val after iterations 4 and 8; o_val after iteration 10.
//   Assert i_reset during iteration 6: all outputs at reset values next cycle.

Source files
------------

// File: rtl/redun_sq_loop_ctrl.sv
// Iteration controller for the redundant Montgomery squaring wrapper: squares a loaded value T times, returns the result.
// Build option REDUN_LOOP_CHKPT_EN publishes the intermediate value on o_result every 2**CHKPT_SHIFT iterations.
module redun_sq_loop_ctrl #(
  parameter int NUM_WRDS    = 65,
  parameter int WRD_BITS    = 16,
  parameter int ITER_BITS   = 40,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CHKPT_SHIFT = 20
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  output logic                         o_ready,
  input  logic [NUM_WRDS*WRD_BITS-1:0] i_sq_init,
  input  logic [ITER_BITS-1:0]         i_iters,
  output logic                         o_sq_start,
  output logic [NUM_WRDS*WRD_BITS-1:0] o_sq_data,
  input  logic [NUM_WRDS*WRD_BITS-1:0] i_sq_out,
  input  logic                         i_sq_valid,
  input  logic                         i_locked,
  output logic [NUM_WRDS*WRD_BITS-1:0] o_result,
  output logic                         o_val,
  input  logic                         i_rdy,
  output logic                         o_err,
  output logic                         o_chkpt_val
);

  localparam int DW = NUM_WRDS * WRD_BITS;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  if (CHKPT_SHIFT < 1 || CHKPT_SHIFT >= ITER_BITS) begin : g_bad_chkpt_shift
    $error("CHKPT_SHIFT must lie in 1..ITER_BITS-1");
  end

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, ISSUE, WAIT_RES, DONE} state_t;

  state_t               state;
  logic [DW-1:0]        work;
  logic [ITER_BITS-1:0] cnt;
  logic [TW-1:0]        tcnt;
  logic                 abort;

`ifdef REDUN_LOOP_CHKPT_EN
  logic [ITER_BITS-1:0] done_cnt;
  logic [ITER_BITS-1:0] done_nxt;
  assign done_nxt = done_cnt + 1'b1;
`else
  assign o_chkpt_val = 1'b0;
`endif

  // Lock loss beats a same-cycle result; a result on the last timeout cycle still counts.
  always_comb begin
    abort = 1'b0;
    if (state == ISSUE)
      abort = !i_locked;
    else if (state == WAIT_RES)
      abort = !i_locked || (!i_sq_valid && tcnt == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_sq_start <= 1'b0;
      o_val      <= 1'b0;
      o_err      <= 1'b0;
      o_sq_data  <= '0;
      o_result   <= '0;
      work       <= '0;
      cnt        <= '0;
      tcnt       <= '0;
`ifdef REDUN_LOOP_CHKPT_EN
      o_chkpt_val <= 1'b0;
      done_cnt    <= '0;
`endif
    end else begin
      o_sq_start <= 1'b0;
      o_err      <= 1'b0;
`ifdef REDUN_LOOP_CHKPT_EN
      o_chkpt_val <= 1'b0;
`endif
      if (abort) begin
        state   <= IDLE;
        o_ready <= 1'b1;
        o_err   <= 1'b1;
        cnt     <= '0;
        tcnt    <= '0;
      end else begin
        case (state)
          IDLE: if (i_start) begin
            work    <= i_sq_init;
            cnt     <= i_iters;
            o_ready <= 1'b0;
`ifdef REDUN_LOOP_CHKPT_EN
            done_cnt <= '0;
`endif
            if (i_iters == '0) begin
              o_result <= i_sq_init;
              o_val    <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT_LOCK;
            end
          end
          // Timeout window opens on the issue cycle itself.
          WAIT_LOCK: if (i_locked) begin
            state      <= ISSUE;
            o_sq_start <= 1'b1;
            o_sq_data  <= work;
            tcnt       <= '0;
          end
          ISSUE: begin
            state <= WAIT_RES;
            tcnt  <= tcnt + 1'b1;
          end
          WAIT_RES: if (i_sq_valid) begin
            work <= i_sq_out;
            cnt  <= cnt - 1'b1;
            if (cnt == ITER_BITS'(1)) begin
              o_result <= i_sq_out;
              o_val    <= 1'b1;
              state    <= DONE;
            end else begin
              state      <= ISSUE;
              o_sq_start <= 1'b1;
              o_sq_data  <= i_sq_out;
              tcnt       <= '0;
`ifdef REDUN_LOOP_CHKPT_EN
              done_cnt <= done_nxt;
              if (done_nxt[CHKPT_SHIFT-1:0] == '0) begin
                o_result    <= i_sq_out;
                o_chkpt_val <= 1'b1;
              end
`endif
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
          DONE: if (i_rdy) begin
            o_val   <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_redun_sq_loop_ctrl.sv
// Randomized bench for redun_sq_loop_ctrl: wrapper model returns x*x after a programmable latency.
module tb_redun_sq_loop_ctrl;
  localparam int NW = 65;
  localparam int WB = 16;
  localparam int IB = 40;
  localparam int TO = 4096;
  localparam int CS = 2;
  localparam int W  = NW * WB;
`ifdef REDUN_LOOP_CHKPT_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ready;
  logic [W-1:0]  sq_init = '0;
  logic [IB-1:0] iters = '0;
  logic          sq_start;
  logic [W-1:0]  sq_data;
  logic [W-1:0]  sq_out = '0;
  logic          sq_valid = 1'b0;
  logic          locked = 1'b1;
  logic [W-1:0]  result;
  logic          val;
  logic          rdy = 1'b0;
  logic          err;
  logic          chkpt_val;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  redun_sq_loop_ctrl #(
    .NUM_WRDS(NW), .WRD_BITS(WB), .ITER_BITS(IB), .TIMEOUT_CYC(TO), .CHKPT_SHIFT(CS)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .o_ready(ready),
    .i_sq_init(sq_init), .i_iters(iters), .o_sq_start(sq_start), .o_sq_data(sq_data),
    .i_sq_out(sq_out), .i_sq_valid(sq_valid), .i_locked(locked), .o_result(result),
    .o_val(val), .i_rdy(rdy), .o_err(err), .o_chkpt_val(chkpt_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper model: start seen in cycle c gives a one-cycle valid in cycle c+wr_lat+1.
  int           wr_lat = 10;
  bit           wr_en = 1'b1;
  int           wr_cnt = 0;
  int           late_req = 0;
  int           late_ack = 0;
  logic [W-1:0] wr_res = '0;

  always @(negedge clk) begin
    sq_valid = 1'b0;
    if (wr_cnt > 0) begin
      wr_cnt = wr_cnt - 1;
      if (wr_cnt == 0 && wr_en) begin
        sq_valid = 1'b1;
        sq_out   = wr_res;
      end
    end
    if (late_req != late_ack) begin
      late_ack = late_req;
      sq_valid = 1'b1;
      sq_out   = '1;
    end
    if (sq_start) begin
      wr_cnt = wr_lat + 1;
      wr_res = sq_data * sq_data;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic bit ckpt_due(input int k, input int t);
    return CK_EN && (k % (1 << CS) == 0) && (k > 0) && (k < t);
  endfunction

  task automatic reset_outputs_check();
    check("rst_ready", ready, 1);
    check("rst_sq_start", sq_start, 0);
    check("rst_val", val, 0);
    check("rst_err", err, 0);
    check("rst_chkpt", chkpt_val, 0);
    check("rst_sq_data", sq_data, 0);
    check("rst_result", result, 0);
  endtask

  // One complete job: load, run to o_val, hold in DONE for 'hold' cycles, accept.
  // rise>0 keeps the lock low from the load until cycle load+rise.
  task automatic run_job(input logic [W-1:0] init, input int t, input int lat,
                         input int hold, input int rise);
    logic [W-1:0] pw [16];
    int load_c, first_s, first_exp, n_s, n_ck, n_ck_exp, n_err, bad, exp_lat;
    bit got_val;
    pw[0] = init;
    for (int i = 1; i <= t; i++) pw[i] = pw[i-1] * pw[i-1];
    n_ck_exp = 0;
    for (int i = 1; i <= t; i++) if (ckpt_due(i, t)) n_ck_exp++;
    wr_lat = lat;
    @(negedge clk);
    check("ready_before_load", ready, 1);
    if (rise > 0) locked = 1'b0;
    sq_init = init;
    iters   = IB'(t);
    start   = 1'b1;
    load_c  = cyc;
    first_exp = (rise > 0) ? load_c + rise + 1 : load_c + 2;
    exp_lat   = (t == 0) ? 1 : (first_exp - load_c) + t * (lat + 2);
    first_s = -1; n_s = 0; n_ck = 0; n_err = 0; got_val = 1'b0;
    for (int c = 0; c < t * (lat + 2) + rise + 20 && !got_val; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rise > 0 && cyc == load_c + rise) locked = 1'b1;
      if (chkpt_val) begin
        n_ck++;
        check("ckpt_due", ckpt_due(n_s, t), 1);
        check("ckpt_value", result, pw[n_s]);
      end
      if (sq_start) begin
        if (first_s < 0) first_s = cyc;
        n_s++;
      end
      if (err) n_err++;
      if (val) got_val = 1'b1;
    end
    check("val_seen", got_val, 1);
    check("val_latency", cyc - load_c, exp_lat);
    check("issue_count", n_s, t);
    if (t > 0) check("first_issue", first_s - load_c, first_exp - load_c);
    check("ckpt_count", n_ck, n_ck_exp);
    check("no_err", n_err, 0);
    check("result", result, pw[t]);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      @(negedge clk);
      if (!val || result !== pw[t] || ready) bad++;
    end
    start = 1'b0;
    check("done_hold_stable", bad, 0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check("accept_val_low", val, 0);
    check("accept_ready", ready, 1);
  endtask

  initial begin
    int s_c, e_c, n;
    repeat (3) @(negedge clk);
    reset_outputs_check();
    reset = 1'b0;

    run_job(W'(5), 3, 10, 0, 0);
    run_job(W'(16'h1234), 0, 10, 0, 0);
    run_job(W'($urandom), 2, 5, 0, 50);

    // lock drop while waiting for a result
    wr_lat = 10;
    @(negedge clk);
    sq_init = W'(9); iters = IB'(3); start = 1'b1;
    s_c = -1;
    for (int c = 0; c < 20 && s_c < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sq_start) s_c = cyc;
    end
    check("drop_issue_seen", s_c >= 0, 1);
    repeat (3) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    check("drop_err", err, 1);
    check("drop_ready", ready, 1);
    locked = 1'b1;
    @(negedge clk);
    check("drop_err_one_cycle", err, 0);
    repeat (12) @(negedge clk);
    check("drop_stays_idle", {val, sq_start, ready}, 3'b001);

    // wrapper never answers
    wr_en = 1'b0;
    @(negedge clk);
    sq_init = W'(3); iters = IB'(2); start = 1'b1;
    s_c = -1;
    for (int c = 0; c < 20 && s_c < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sq_start) s_c = cyc;
    end
    e_c = -1;
    for (int c = 0; c < TO + 20 && e_c < 0; c++) begin
      @(negedge clk);
      if (err) e_c = cyc;
    end
    check("timeout_cycle", e_c - s_c, TO);
    @(negedge clk);
    check("timeout_idle", ready, 1);
    check("timeout_err_one_cycle", err, 0);
    late_req++;
    repeat (4) @(negedge clk);
    check("late_valid_ignored", {val, sq_start, ready, err}, 4'b0010);
    wr_en = 1'b1;

    run_job(W'($urandom), 2, 3, 20, 0);
    run_job(W'($urandom), 3, 2, 0, 0);
    run_job(W'(7), 10, 3, 0, 0);

    // synchronous reset during iteration 6
    wr_lat = 4;
    @(negedge clk);
    sq_init = W'(3); iters = IB'(10); start = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sq_start) n++;
    end
    check("rst_reached_iter6", n, 6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reset_outputs_check();
    repeat (8) @(negedge clk);
    check("rst_stale_valid_dropped", {val, sq_start, ready}, 3'b001);

    for (int j = 0; j < 6; j++)
      run_job(W'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 8)),
              int'($urandom_range(0, 4)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
